// File: rtl/vbus_pkg.sv
// Shared constants for the CPU-to-video bus controller: register map,
// bus FSM encoding, ctrl bit positions and reset values.
package vbus_pkg;

  // Register select indices
  localparam logic [3:0] REG_DATA    = 4'h0;
  localparam logic [3:0] REG_ADDR_LO = 4'h1;
  localparam logic [3:0] REG_ADDR_HI = 4'h2;
  localparam logic [3:0] REG_CTRL    = 4'h3;
  localparam logic [3:0] REG_CUR_CH  = 4'h4;
  localparam logic [3:0] REG_CUR_X   = 4'h5;
  localparam logic [3:0] REG_CUR_Y   = 4'h6;
  localparam logic [3:0] REG_HSHIFT  = 4'h7;
  localparam logic [3:0] REG_STRIDE  = 4'h8;
  localparam logic [3:0] REG_STATUS  = 4'h9;
  localparam logic [3:0] REG_FCNT_LO = 4'hA;
  localparam logic [3:0] REG_FCNT_HI = 4'hB;
  localparam logic [3:0] REG_FILL    = 4'hC;

  // Bus FSM, one-hot
  typedef enum logic [5:0] {
    S_IDLE     = 6'b00_0001,
    S_RD_START = 6'b00_0010,
    S_RD_WAIT  = 6'b00_0100,
    S_WR_START = 6'b00_1000,
    S_WR_WAIT  = 6'b01_0000,
    S_FETCH    = 6'b10_0000
  } bus_state_e;

  // Bit positions inside the ctrl register
  localparam int unsigned CTRL_VID_MODE  = 7;
  localparam int unsigned CTRL_BLINK_ON  = 6;
  localparam int unsigned CTRL_RD_INC    = 3;
  localparam int unsigned CTRL_CURSOR_ON = 1;
  localparam int unsigned CTRL_WR_INC    = 0;

  // Reset values
  localparam logic [7:0] RST_CURSOR_CH = 8'h5F;
  localparam logic [3:0] RST_HSHIFT    = 4'b0111;
  localparam logic [7:0] RST_STRIDE    = 8'h01;

  // Strobe synchroniser width: cs, rd, wr
  localparam int unsigned SYNC_W = 3;

  // Writes to these registers would disturb the VRAM port and are refused during a fill
  function automatic logic wr_blocked_when_busy(input logic [3:0] sel);
    return (sel == REG_DATA) || (sel == REG_ADDR_LO) ||
           (sel == REG_ADDR_HI) || (sel == REG_FILL);
  endfunction

endpackage

// File: rtl/vbus_sync.sv
// Two-flop synchroniser for the (already inverted) CPU strobes.
module vbus_sync #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Metastability filter, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/vbus_ctrl.sv
// CPU bus interface for the text/video controller: register file, VRAM
// port with read prefetch, signed auto-increment and a block-fill engine.
module vbus_ctrl #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned CURX_W = 7,
  parameter int unsigned CURY_W = 5,
  parameter int unsigned FILL_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csb,
  input  logic              rdb,
  input  logic              wrb,
  input  logic [3:0]        rs,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              dout_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_wen,
  output logic              ram_rd_en,
  input  logic [7:0]        ram_rdata,
  output logic              vid_mode,
  output logic              blink_on,
  output logic              cursor_on,
  output logic [CURX_W-1:0] cursor_x,
  output logic [CURY_W-1:0] cursor_y,
  output logic [7:0]        cursor_ch,
  output logic [3:0]        hshift,
  output logic              busy
);

  import vbus_pkg::*;

  localparam int unsigned HI_W  = ADDR_W - 8;
  localparam int unsigned LAT_W = 3;

  // Synchronised strobes
  logic [SYNC_W-1:0] strobe_s;
  logic              cs_s, rd_s, wr_s;
  logic              rd, wr;

  vbus_sync #(.W(SYNC_W)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i ({~csb, ~rdb, ~wrb}),
    .sync_o  (strobe_s)
  );

  assign cs_s = strobe_s[2];
  assign rd_s = strobe_s[1];
  assign wr_s = strobe_s[0];
  assign rd   = cs_s & rd_s;
  assign wr   = cs_s & wr_s;

  // Bus FSM and transaction bookkeeping
  bus_state_e        state_q;
  logic [3:0]        rs_q;
  logic              drop_q;
  logic              ret_rd_q;
  logic              fetch_pend_q;
  logic [LAT_W-1:0]  lat_q;

  // Register file
  logic              vid_mode_q, blink_on_q, cursor_on_q, wr_inc_q, rd_inc_q;
  logic [CURX_W-1:0] cursor_x_q;
  logic [CURY_W-1:0] cursor_y_q;
  logic [7:0]        cursor_ch_q;
  logic [3:0]        hshift_q;
  logic [7:0]        stride_q;
  logic [FILL_W-1:0] fill_cnt_q;
  logic              overrun_q;
  logic [7:0]        pbuf_q;

  // Fill engine
  logic              busy_q;
  logic [FILL_W-1:0] work_cnt_q;
  logic [7:0]        fill_val_q;

  // VRAM port and CPU read data
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_wdata_q;
  logic              ram_wen_q;
  logic              ram_rd_en_q;
  logic [7:0]        dout_q;

  logic [7:0]        rd_data_c;
  logic [ADDR_W-1:0] addr_step_c;

  // Address plus sign-extended stride, wrapping at the address width
  assign addr_step_c = ram_addr_q + {{HI_W{stride_q[7]}}, stride_q};

  // Register read multiplexer
  always_comb begin
    rd_data_c = 8'hFF;
    case (rs_q)
      REG_DATA:    rd_data_c = pbuf_q;
      REG_ADDR_LO: rd_data_c = ram_addr_q[7:0];
      REG_ADDR_HI: rd_data_c = 8'(ram_addr_q[ADDR_W-1:8]);
      REG_CTRL:    rd_data_c = {vid_mode_q, blink_on_q, 2'b00, rd_inc_q, 1'b0, cursor_on_q, wr_inc_q};
      REG_CUR_CH:  rd_data_c = cursor_ch_q;
      REG_CUR_X:   rd_data_c = 8'(cursor_x_q);
      REG_CUR_Y:   rd_data_c = 8'(cursor_y_q);
      REG_HSHIFT:  rd_data_c = {4'b0000, hshift_q};
      REG_STRIDE:  rd_data_c = stride_q;
      REG_STATUS:  rd_data_c = {6'b00_0000, overrun_q, busy_q};
      REG_FCNT_LO: rd_data_c = fill_cnt_q[7:0];
      REG_FCNT_HI: rd_data_c = 8'(fill_cnt_q[FILL_W-1:8]);
      default:     rd_data_c = 8'hFF;
    endcase
  end

  // Bus FSM, register file, fill engine and VRAM port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rs_q         <= 4'h0;
      drop_q       <= 1'b0;
      ret_rd_q     <= 1'b0;
      fetch_pend_q <= 1'b0;
      lat_q        <= '0;
      vid_mode_q   <= 1'b0;
      blink_on_q   <= 1'b1;
      cursor_on_q  <= 1'b1;
      wr_inc_q     <= 1'b1;
      rd_inc_q     <= 1'b1;
      cursor_x_q   <= '0;
      cursor_y_q   <= '0;
      cursor_ch_q  <= RST_CURSOR_CH;
      hshift_q     <= RST_HSHIFT;
      stride_q     <= RST_STRIDE;
      fill_cnt_q   <= '0;
      overrun_q    <= 1'b0;
      pbuf_q       <= 8'h00;
      busy_q       <= 1'b0;
      work_cnt_q   <= '0;
      fill_val_q   <= 8'h00;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 8'h00;
      ram_wen_q    <= 1'b0;
      ram_rd_en_q  <= 1'b0;
      dout_q       <= 8'h00;
    end else begin
      ram_wen_q   <= 1'b0;
      ram_rd_en_q <= 1'b0;

      // Fill: the trigger issues the first write; each busy cycle steps past
      // the write just shown and issues the next one until the count runs out
      if (busy_q) begin
        ram_addr_q <= addr_step_c;
        work_cnt_q <= work_cnt_q - FILL_W'(1);
        if (work_cnt_q == FILL_W'(1)) begin
          busy_q       <= 1'b0;
          fetch_pend_q <= 1'b1;
        end else begin
          ram_wen_q   <= 1'b1;
          ram_wdata_q <= fill_val_q;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (rd) begin
            rs_q    <= rs;
            state_q <= S_RD_START;
          end else if (wr) begin
            rs_q    <= rs;
            state_q <= S_WR_START;
          end else if (fetch_pend_q) begin
            ret_rd_q <= 1'b0;
            lat_q    <= '0;
            state_q  <= S_FETCH;
          end
        end

        S_RD_START: begin
          drop_q <= 1'b0;
          if (rs_q == REG_DATA && busy_q) begin
            dout_q    <= pbuf_q;
            overrun_q <= 1'b1;
            drop_q    <= 1'b1;
            state_q   <= S_RD_WAIT;
          end else if (rs_q == REG_DATA && fetch_pend_q) begin
            // Buffer is stale after a fill: refresh it, then return here
            ret_rd_q <= 1'b1;
            lat_q    <= '0;
            state_q  <= S_FETCH;
          end else begin
            dout_q <= rd_data_c;
            if (rs_q == REG_STATUS) begin
              overrun_q <= 1'b0;
            end
            state_q <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (!rd) begin
            if (rs_q == REG_DATA && rd_inc_q && !drop_q) begin
              ram_addr_q <= addr_step_c;
              ret_rd_q   <= 1'b0;
              lat_q      <= '0;
              state_q    <= S_FETCH;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        S_WR_START: begin
          drop_q  <= 1'b0;
          state_q <= S_WR_WAIT;
          if (busy_q && wr_blocked_when_busy(rs_q)) begin
            overrun_q <= 1'b1;
            drop_q    <= 1'b1;
          end else begin
            case (rs_q)
              REG_DATA: begin
                ram_wdata_q <= din;
                ram_wen_q   <= 1'b1;
              end
              REG_ADDR_LO: ram_addr_q[7:0] <= din;
              REG_ADDR_HI: ram_addr_q[ADDR_W-1:8] <= din[HI_W-1:0];
              REG_CTRL: begin
                vid_mode_q  <= din[CTRL_VID_MODE];
                blink_on_q  <= din[CTRL_BLINK_ON];
                rd_inc_q    <= din[CTRL_RD_INC];
                cursor_on_q <= din[CTRL_CURSOR_ON];
                wr_inc_q    <= din[CTRL_WR_INC];
              end
              REG_CUR_CH:  cursor_ch_q <= din;
              REG_CUR_X:   cursor_x_q  <= din[CURX_W-1:0];
              REG_CUR_Y:   cursor_y_q  <= din[CURY_W-1:0];
              REG_HSHIFT:  hshift_q    <= din[3:0];
              REG_STRIDE:  stride_q    <= din;
              REG_FCNT_LO: fill_cnt_q[7:0] <= din;
              REG_FCNT_HI: fill_cnt_q[FILL_W-1:8] <= din[FILL_W-9:0];
              REG_FILL: begin
                if (fill_cnt_q != '0) begin
                  busy_q      <= 1'b1;
                  work_cnt_q  <= fill_cnt_q;
                  fill_val_q  <= din;
                  ram_wdata_q <= din;
                  ram_wen_q   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        S_WR_WAIT: begin
          if (!wr) begin
            if (!drop_q && rs_q == REG_DATA && wr_inc_q) begin
              ram_addr_q <= addr_step_c;
              ret_rd_q   <= 1'b0;
              lat_q      <= '0;
              state_q    <= S_FETCH;
            end else if (!drop_q && (rs_q == REG_ADDR_LO || rs_q == REG_ADDR_HI)) begin
              ret_rd_q <= 1'b0;
              lat_q    <= '0;
              state_q  <= S_FETCH;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        S_FETCH: begin
          // Strobe shows at lat=1; data is valid RD_LAT cycles later
          lat_q <= lat_q + LAT_W'(1);
          if (lat_q == '0) begin
            ram_rd_en_q <= 1'b1;
          end
          if (lat_q == LAT_W'(RD_LAT + 1)) begin
            pbuf_q       <= ram_rdata;
            fetch_pend_q <= 1'b0;
            state_q      <= ret_rd_q ? S_RD_START : S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dout_en   = rd;
  assign dout      = dout_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wen   = ram_wen_q;
  assign ram_rd_en = ram_rd_en_q;
  assign vid_mode  = vid_mode_q;
  assign blink_on  = blink_on_q;
  assign cursor_on = cursor_on_q;
  assign cursor_x  = cursor_x_q;
  assign cursor_y  = cursor_y_q;
  assign cursor_ch = cursor_ch_q;
  assign hshift    = hshift_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vbus_ctrl.sv
// Bench for vbus_ctrl: CPU bus tasks, a VRAM model and scoreboard queues
// for expected read data and expected VRAM writes.
module tb_vbus_ctrl;

  localparam int unsigned ADDR_W = 14;

  logic              clk;
  logic              reset;
  logic              csb, rdb, wrb;
  logic [3:0]        rs;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic              dout_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_wen;
  logic              ram_rd_en;
  logic [7:0]        ram_rdata;
  logic              vid_mode, blink_on, cursor_on;
  logic [6:0]        cursor_x;
  logic [4:0]        cursor_y;
  logic [7:0]        cursor_ch;
  logic [3:0]        hshift;
  logic              busy;

  vbus_ctrl #(.ADDR_W(ADDR_W), .CURX_W(7), .CURY_W(5), .FILL_W(16), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .csb(csb), .rdb(rdb), .wrb(wrb), .rs(rs), .din(din),
    .dout(dout), .dout_en(dout_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wen(ram_wen), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata),
    .vid_mode(vid_mode), .blink_on(blink_on), .cursor_on(cursor_on),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_ch(cursor_ch),
    .hshift(hshift), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int busy_cyc = 0;
  int rden_cnt = 0;

  // Scoreboards
  logic [7:0]        rd_exp_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [7:0]        wr_data_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // VRAM model with one-cycle read latency and a bench preload port
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              pre_en;
  logic [ADDR_W-1:0] pre_addr;
  logic [7:0]        pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
  end

  // Write monitor: every VRAM write must match the next expected one
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cyc++;
      if (ram_rd_en) rden_cnt++;
      if (ram_wen) begin
        logic have;
        have = (wr_addr_q.size() != 0);
        check("wen_rden_excl", 32'(ram_rd_en), 32'd0);
        check("wen_expected", 32'(have), 32'd1);
        if (have) begin
          check("wen_addr", 32'(ram_addr), 32'(wr_addr_q.pop_front()));
          check("wen_data", 32'(ram_wdata), 32'(wr_data_q.pop_front()));
        end
      end
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    wr_addr_q.push_back(a);
    wr_data_q.push_back(d);
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    rs = a; din = d; csb = 1'b0; wrb = 1'b0;
    repeat (6) @(negedge clk);
    csb = 1'b1; wrb = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic cpu_rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] e;
    rd_exp_q.push_back(exp);
    @(negedge clk);
    rs = a; csb = 1'b0; rdb = 1'b0;
    repeat (10) @(negedge clk);
    check({tag, "_den"}, 32'(dout_en), 32'd1);
    e = rd_exp_q.pop_front();
    check(tag, 32'(dout), 32'(e));
    csb = 1'b1; rdb = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int rc0;
    reset = 1'b1; csb = 1'b1; rdb = 1'b1; wrb = 1'b1;
    rs = 4'h0; din = 8'h00; pre_en = 1'b0; pre_addr = '0; pre_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_addr", 32'(ram_addr), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wen", 32'(ram_wen), 32'd0);
    check("rst_den", 32'(dout_en), 32'd0);
    check("rst_ctl", 32'({vid_mode, blink_on, cursor_on}), 32'b011);
    check("rst_cch", 32'(cursor_ch), 32'h5F);
    check("rst_hsh", 32'(hshift), 32'h7);
    cpu_rd("rd_ctrl", 4'h3, 8'h4B);
    cpu_rd("rd_cch", 4'h4, 8'h5F);
    cpu_rd("rd_hsh", 4'h7, 8'h07);
    cpu_rd("rd_stat0", 4'h9, 8'h00);
    cpu_rd("rd_fill", 4'hC, 8'hFF);
    cpu_rd("rd_regE", 4'hE, 8'hFF);

    // Data writes with auto-increment
    cpu_wr(4'h2, 8'h01);
    cpu_wr(4'h1, 8'h00);
    exp_wr(14'h0100, 8'hAA);
    cpu_wr(4'h0, 8'hAA);
    exp_wr(14'h0101, 8'hBB);
    cpu_wr(4'h0, 8'hBB);
    cpu_rd("rd_alo", 4'h1, 8'h02);
    cpu_rd("rd_ahi", 4'h2, 8'h01);

    // Negative stride wraps below zero
    cpu_wr(4'h8, 8'hFF);
    cpu_wr(4'h1, 8'h00);
    cpu_wr(4'h2, 8'h00);
    exp_wr(14'h0000, 8'h11);
    cpu_wr(4'h0, 8'h11);
    check("wrap_addr", 32'(ram_addr), 32'h3FFF);
    cpu_rd("rd_ahi_wrap", 4'h2, 8'h3F);
    cpu_rd("rd_stride", 4'h8, 8'hFF);

    // Read-back with prefetch
    cpu_wr(4'h8, 8'h01);
    preload(14'h0020, 8'h41);
    preload(14'h0021, 8'h42);
    cpu_wr(4'h2, 8'h00);
    cpu_wr(4'h1, 8'h20);
    rc0 = rden_cnt;
    cpu_rd("pf_rd0", 4'h0, 8'h41);
    cpu_rd("pf_rd1", 4'h0, 8'h42);
    check("pf_rden", 32'(rden_cnt - rc0), 32'd2);
    check("pf_addr", 32'(ram_addr), 32'h0022);

    // Short fill, stride +2
    preload(14'h0018, 8'h5A);
    cpu_wr(4'hA, 8'h04);
    cpu_wr(4'hB, 8'h00);
    cpu_wr(4'h8, 8'h02);
    cpu_wr(4'h2, 8'h00);
    cpu_wr(4'h1, 8'h10);
    for (int i = 0; i < 4; i++) exp_wr(14'(16 + 2 * i), 8'h20);
    busy_cyc = 0;
    cpu_wr(4'hC, 8'h20);
    check("fill_busy_cyc", 32'(busy_cyc), 32'd4);
    check("fill_addr", 32'(ram_addr), 32'h0018);
    check("fill_drain", 32'(wr_addr_q.size()), 32'd0);
    cpu_rd("fill_fetch", 4'h0, 8'h5A);

    // Long fill with refused and serviced accesses while busy
    cpu_wr(4'h8, 8'h01);
    preload(14'h0200, 8'h3C);
    cpu_wr(4'hA, 8'h00);
    cpu_wr(4'hB, 8'h01);
    cpu_wr(4'h2, 8'h02);
    cpu_wr(4'h1, 8'h00);
    for (int i = 0; i < 256; i++) exp_wr(14'(14'h0200 + i), 8'h77);
    cpu_wr(4'hC, 8'h77);
    check("lf_busy", 32'(busy), 32'd1);
    cpu_wr(4'h0, 8'h99);
    cpu_rd("lf_stale", 4'h0, 8'h3C);
    cpu_wr(4'h5, 8'h12);
    cpu_rd("lf_curx", 4'h5, 8'h12);
    check("lf_curx_out", 32'(cursor_x), 32'h12);
    cpu_rd("lf_stat", 4'h9, 8'h03);
    cpu_rd("lf_stat_clr", 4'h9, 8'h01);
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
    check("lf_done", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    cpu_rd("lf_stat_end", 4'h9, 8'h00);
    cpu_rd("lf_fcnt_hi", 4'hB, 8'h01);
    check("lf_addr", 32'(ram_addr), 32'h0300);
    check("lf_drain", 32'(wr_addr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
